// File: rtl/pipeline_mult_add.sv
// Three-stage valid/ready pipeline computing (a*b*c)+d, with a completed-result counter.
// Define PIPELINE_MULT_ADD_SAT_EN to saturate out instead of wrapping it.
module pipeline_mult_add #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam int P1_W = 2 * WIDTH;
  localparam int P2_W = 3 * WIDTH;
  localparam int R_W  = 3 * WIDTH + 1;

  logic             v1_reg, v2_reg, v3_reg;
  logic [P1_W-1:0]  p1_reg;
  logic [WIDTH-1:0] c1_reg, d1_reg, d2_reg;
  logic [P2_W-1:0]  p2_reg;
  logic [OUT_W-1:0] out_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             adv1, adv2, adv3;
  logic [P1_W-1:0]  p1_next;
  logic [P2_W-1:0]  p2_next;
  logic [R_W-1:0]   r_next;
  logic [OUT_W-1:0] out_next;

  // A stage may take new data when it is empty or its entry moves on this cycle.
  assign adv3     = !v3_reg || out_ready;
  assign adv2     = !v2_reg || adv3;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;

  assign p1_next = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign p2_next = {{WIDTH{1'b0}}, p1_reg} * {{P1_W{1'b0}}, c1_reg};
  assign r_next  = {1'b0, p2_reg} + {{(P2_W + 1){1'b0}}, d2_reg};

  generate
    if (OUT_W < R_W) begin : g_narrow
`ifdef PIPELINE_MULT_ADD_SAT_EN
      assign out_next = (|r_next[R_W-1:OUT_W]) ? {OUT_W{1'b1}} : r_next[OUT_W-1:0];
`else
      logic unused_hi;
      assign unused_hi = ^r_next[R_W-1:OUT_W];
      assign out_next  = r_next[OUT_W-1:0];
`endif
    end else begin : g_full
      assign out_next = r_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      v3_reg  <= 1'b0;
      out_reg <= '0;
      cnt_reg <= '0;
    end else begin
      if (adv1) v1_reg <= in_valid;
      if (adv2) v2_reg <= v1_reg;
      if (adv3) v3_reg <= v2_reg;
      if (adv3 && v2_reg) out_reg <= out_next;
      if (v3_reg && out_ready) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Intermediate data carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      p1_reg <= p1_next;
      c1_reg <= c;
      d1_reg <= d;
    end
    if (v1_reg && adv2) begin
      p2_reg <= p2_next;
      d2_reg <= d1_reg;
    end
  end

  assign out        = out_reg;
  assign out_valid  = v3_reg;
  assign busy       = v1_reg || v2_reg || v3_reg;
  assign done_count = cnt_reg;

endmodule

// File: tb/tb_pipeline_mult_add.sv
// Directed bench for pipeline_mult_add: queue-based scoreboard checked every cycle plus literal expectations.
module tb_pipeline_mult_add;
  localparam int WIDTH = 8;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  pipeline_mult_add #(.WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct { longint v; int t; } entry_t;
  entry_t      sb[$];
  longint      log_v[$];
  int          log_t[$];
  int          exp_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected output straight from the arithmetic definition of the block.
  function automatic longint model(input longint ma, mb, mc, md);
    longint r;
    r = ma * mb * mc + md;
`ifdef PIPELINE_MULT_ADD_SAT_EN
    if (r >= 65536) return 65535;
    return r;
`else
    return r % 65536;
`endif
  endfunction

  // Compare process: states are sampled at negedge; transfers take effect at the next posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_ov;
      exp_ov = (sb.size() != 0) && (cyc >= sb[0].t + 2);
      check("out_valid", out_valid, exp_ov);
      check("busy", busy, sb.size() != 0);
      check("in_ready", in_ready, (sb.size() < 3) || out_ready);
      check("done_count", done_count, exp_cnt % 16);
      if (out_valid && exp_ov) check("out", out, sb[0].v);
      if (reset) begin
        sb.delete();
        exp_cnt = 0;
      end else begin
        if (out_valid && out_ready && sb.size() != 0) begin
          log_v.push_back(out);
          log_t.push_back(cyc + 1);
          void'(sb.pop_front());
          exp_cnt++;
        end
        if (in_valid && in_ready) begin
          entry_t e;
          e.v = model(a, b, c, d);
          e.t = cyc + 1;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic send(input int va, vb, vc, vd, output int edge_no);
    bit ok;
    int n;
    a = va; b = vb; c = vc; d = vd;
    in_valid = 1'b1;
    n = 0;
    edge_no = -1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (ok) edge_no = cyc;
    else check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, e, k;
    int vals[4][4];
    longint stream_exp[6];
    do_reset();
    do_reset();
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // Single transfer: 3*4*5+6 = 66, delivered three edges after acceptance.
    log_v.delete(); log_t.delete();
    send(3, 4, 5, 6, e0);
    idle(6);
    check("t1_count", log_v.size(), 1);
    if (log_v.size() == 1) begin
      check("t1_value", log_v[0], 66);
      check("t1_latency", log_t[0] - e0, 3);
    end
    check("t1_done", done_count, 1);

    // Full-scale operands.
    log_v.delete(); log_t.delete();
    send(255, 255, 255, 255, e0);
    idle(6);
    check("t2_count", log_v.size(), 1);
`ifdef PIPELINE_MULT_ADD_SAT_EN
    if (log_v.size() == 1) check("t2_value", log_v[0], 'hFFFF);
`else
    if (log_v.size() == 1) check("t2_value", log_v[0], 'h03FE);
`endif

    // Back-to-back: 1, 9, 29, 67 on consecutive edges.
    log_v.delete(); log_t.delete();
    vals = '{'{1,1,1,0}, '{2,2,2,1}, '{3,3,3,2}, '{4,4,4,3}};
    send(vals[0][0], vals[0][1], vals[0][2], vals[0][3], e0);
    for (int i = 1; i < 4; i++) send(vals[i][0], vals[i][1], vals[i][2], vals[i][3], e);
    idle(8);
    check("t3_count", log_v.size(), 4);
    if (log_v.size() == 4) begin
      check("t3_v0", log_v[0], 1);
      check("t3_v1", log_v[1], 9);
      check("t3_v2", log_v[2], 29);
      check("t3_v3", log_v[3], 67);
      for (int i = 0; i < 4; i++) check("t3_edge", log_t[i] - e0, 3 + i);
    end

    // Backpressure: offer continuously for 6 cycles with out_ready low.
    log_v.delete(); log_t.delete();
    for (int i = 0; i < 6; i++) stream_exp[i] = model(i + 10, i + 20, i + 2, i * 7);
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit ok;
      a = k + 10; b = k + 20; c = k + 2; d = k * 7;
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) k++;
    end
    in_valid = 1'b0;
    check("t4_accepted", k, 3);
    check("t4_held_out", out, stream_exp[0]);
    out_ready = 1'b1;
    for (int i = k; i < 6; i++) send(i + 10, i + 20, i + 2, i * 7, e);
    idle(8);
    check("t4_count", log_v.size(), 6);
    if (log_v.size() == 6)
      for (int i = 0; i < 6; i++) check("t4_order", log_v[i], stream_exp[i]);

    // Reset with three entries in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i + 1, 2, 3, 4, e);
    check("t5_full_busy", busy, 1);
    do_reset();
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done_count, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_out", out, 0);
    out_ready = 1'b1;
    log_v.delete(); log_t.delete();
    send(7, 6, 5, 9, e0);
    idle(6);
    check("t5_count", log_v.size(), 1);
    if (log_v.size() == 1) begin
      check("t5_value", log_v[0], 219);
      check("t5_latency", log_t[0] - e0, 3);
    end

    // Counter wrap: 16 results with a 4-bit counter.
    do_reset();
    log_v.delete(); log_t.delete();
    for (int i = 0; i < 16; i++) begin
      send(i, 3, 1, i, e);
      if (i == 14) begin
        idle(5);
        check("t6_done15", done_count, 15);
      end
    end
    idle(6);
    check("t6_count", log_v.size(), 16);
    check("t6_wrap", done_count, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
